mips_mc_core: RTL and testbench
===============================

Name: mips_mc_core

Overview:
- Self-contained multicycle MIPS-I subset core with its own control FSM; no externally supplied state count.
- Generalises the current datapath top:
  - parametrised data width, address width and reset vector;
  - a single unified memory port with a req/ready wait-state handshake;
  - illegal-opcode trap to a HALT state.
- Sits between the board-level memory (ROM/RAM decode lives outside) and the debug/LED logic.

Parameters:
- DATA_WIDTH, 32, register/ALU/PC width (>=16).
- ADDR_WIDTH, 8, word-address width presented on mem_addr.
- RESET_PC, 0, byte address loaded into PC on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory access request, held until accepted.
- mem_we  out  1  1=write, 0=read; valid while mem_req.
- mem_addr  out  ADDR_WIDTH  word address = byte_addr[ADDR_WIDTH+1:2].
- mem_wdata  out  DATA_WIDTH  store data; valid while mem_req & mem_we.
- mem_rdata  in  DATA_WIDTH  read data; sampled on the cycle mem_ready=1.
- mem_ready  in  1  access complete this cycle.
- halted  out  1  core is in HALT.
- pc_dbg  out  DATA_WIDTH  current PC.
- state_dbg  out  4  FSM state encoding.

Behaviour:
- Reset (async) values: PC=RESET_PC; FSM=FETCH; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; halted=0. IR, A, B, ALUOut, MDR and all 32 registers are cleared to 0.
- $zero: writes are discarded; reads always return 0.
- Every access state (FETCH, MEMRD, MEMWR):
  - mem_req=1 with stable addr, we and wdata until a cycle with mem_ready=1.
  - The FSM advances on that cycle; mem_req drops in the next state.
  - mem_ready while mem_req=0 is ignored.
- FETCH: addr=PC>>2. On ready: IR<=mem_rdata, PC<=PC+4 (wraps modulo 2^DATA_WIDTH), go to DECODE.
- DECODE (1 cycle):
  - A<=RF[rs], B<=RF[rt].
  - ALUOut<=PC+(signext(imm)<<2), the branch target.
  - Dispatch on opcode:
    - lw/sw -> MEMADR
    - R-type -> EXEC
    - addi -> ADDIEX
    - beq -> BRANCH
    - j -> JUMP
    - else -> HALT
- MEMADR: ALUOut<=A+signext(imm). lw -> MEMRD; sw -> MEMWR.
- MEMRD: on ready, MDR<=mem_rdata, go to MEMWB.
- MEMWB: RF[rt]<=MDR, go to FETCH.
- MEMWR: addr=ALUOut>>2, we=1, wdata=B. On ready, go to FETCH.
- EXEC: ALUOut<=A op B, then ALUWB.
  - funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00 (B<<shamt).
  - Any other funct -> HALT, no write.
- ALUWB: RF[rd]<=ALUOut, go to FETCH.
- ADDIEX: ALUOut<=A+signext(imm), then ADDIWB: RF[rt]<=ALUOut.
- BRANCH: if A==B, PC<=ALUOut. Always go to FETCH.
- JUMP: PC<={PC[DATA_WIDTH-1:28], addr26, 2'b00}, go to FETCH.
  - When DATA_WIDTH<32, the concatenation is truncated to DATA_WIDTH.
- Arithmetic: overflow is ignored and results wrap. slt is signed and yields 0 or 1, zero-extended.
- HALT: sticky, halted=1, no memory requests, PC frozen. Exit only by reset.
- Cycle counts with zero wait states:
  - lw 5
  - sw 4
  - R-type, addi 4
  - beq, j 3
  - Each wait cycle adds 1.
- Reset asserted mid-access: mem_req drops immediately (asynchronous); no register-file write occurs.

Optional Feature:
- MIPS_MC_JUMP_LINK_EN defined:
  - jal (opcode 0x03): RF[31]<=PC (already PC+4), then JUMP behaviour, via state JALWB.
  - jr (R-type funct 0x08): PC<=A, then FETCH.
- Undefined: both opcodes go to HALT.

Decomposition:
- Package mips_mc_pkg:
  - state enum;
  - opcode constants (RTYPE 0x00, J 0x02, JAL 0x03, BEQ 0x04, ADDI 0x08, LW 0x23, SW 0x2B);
  - funct constants;
  - ALU op enum.
- One sub-module, mips_mc_regfile: 32xDATA_WIDTH, 2 combinational read ports, 1 synchronous write port, $zero hardwired.

Test Plan:
- Reset with RESET_PC=0x40, mem_ready tied 1 -> first mem_req at addr 0x10, pc_dbg=0x40.
- Program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sw $3,8($0)` -> write at addr 2, wdata 0x00000002, 16 cycles total.
- lw with mem_ready delayed 3 cycles on both fetch and data read -> mem_addr/mem_req stable throughout, RF written once, total 11 cycles.
- `beq $1,$1,-1` -> PC returns to the beq address; `beq $1,$2,+2` with $1!=$2 -> PC+4.
- Opcode 0x3F -> halted=1 after DECODE, mem_req stays 0 for 100 cycles; reset clears halted.
- With MIPS_MC_JUMP_LINK_EN: jal at 0x100 -> $31=0x104; a following jr $31 returns to 0x104. Without the macro the same jal halts.

Source files
------------

// File: rtl/mips_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_mc_pkg                                                     |
// | Purpose  : Shared types and constants for the multicycle MIPS-I core:      |
// |            FSM state encoding, opcode/funct constants, ALU op decode.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mips_mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_ADDIEX = 4'd8,
    ST_ADDIWB = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_JALWB  = 4'd12,
    ST_HALT   = 4'd13
  } state_e;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_sll = 6'h00;
  localparam logic [5:0] c_fn_jr  = 6'h08;
  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic    valid;
    alu_op_e op;
  } alu_dec_t;

  // Maps an R-type funct field onto an ALU operation; valid=0 for anything
  // the ALU does not implement (jr is handled separately by the FSM).
  function automatic alu_dec_t decode_funct(input logic [5:0] funct);
    alu_dec_t d;
    d.valid = 1'b1;
    d.op    = ALU_ADD;
    case (funct)
      c_fn_add: d.op = ALU_ADD;
      c_fn_sub: d.op = ALU_SUB;
      c_fn_and: d.op = ALU_AND;
      c_fn_or:  d.op = ALU_OR;
      c_fn_slt: d.op = ALU_SLT;
      c_fn_sll: d.op = ALU_SLL;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mc_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_mc_regfile                                                 |
// | Purpose  : 32 x DATA_WIDTH register file, two combinational read ports,    |
// |            one synchronous write port, register 0 hardwired to zero.       |
// | Ports    : clk, reset (async, active-high, clears all registers)           |
// |            rd_addr_a/rd_data_a, rd_addr_b/rd_data_b : read ports           |
// |            wr_en/wr_addr/wr_data                    : write port           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mips_mc_regfile
  import mips_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [4:0]            rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] r_regs [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == 5'd0) ? '0 : r_regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? '0 : r_regs[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/mips_mc_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_mc_core                                                    |
// | Purpose  : Multicycle MIPS-I subset core (lw, sw, add, sub, and, or, slt,  |
// |            sll, addi, beq, j) with a unified req/ready memory port and an  |
// |            illegal-instruction trap into a sticky HALT state.              |
// | Options  : MIPS_MC_JUMP_LINK_EN - adds jal and jr; otherwise both halt.    |
// | Ports    : clk, reset (async, active-high)                                 |
// |            mem_req/mem_we/mem_addr/mem_wdata : access request (word addr)  |
// |            mem_rdata/mem_ready               : access completion           |
// |            halted, pc_dbg, state_dbg         : debug/status                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] pc_dbg,
  output logic [3:0]            state_dbg
);

  // Low 28 bits of a jump target come from the instruction; the rest from PC.
  localparam logic [DATA_WIDTH-1:0] c_jmask = DATA_WIDTH'(28'hFFF_FFFF);

  state_e                r_state, w_next_state;
  logic [DATA_WIDTH-1:0] r_pc, r_a, r_b, r_aluout, r_mdr;
  logic [31:0]           r_ir;  // instructions are always 32 bits wide

  logic [5:0]            w_opcode, w_funct;
  logic [4:0]            w_rs, w_rt, w_rd, w_shamt;
  logic [DATA_WIDTH-1:0] w_simm, w_alu_y, w_jump_tgt, w_rd_a, w_rd_b;
  alu_dec_t              w_alu_dec;
  logic                  w_rf_we;
  logic [4:0]            w_rf_waddr;
  logic [DATA_WIDTH-1:0] w_rf_wdata;

  assign w_opcode  = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_shamt   = r_ir[10:6];
  assign w_funct   = r_ir[5:0];
  assign w_simm    = DATA_WIDTH'($signed(r_ir[15:0]));
  assign w_alu_dec = decode_funct(w_funct);
  assign w_jump_tgt = (r_pc & ~c_jmask) | (DATA_WIDTH'({r_ir[25:0], 2'b00}) & c_jmask);

  mips_mc_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (w_rs),
    .rd_data_a (w_rd_a),
    .rd_addr_b (w_rt),
    .rd_data_b (w_rd_b),
    .wr_en     (w_rf_we),
    .wr_addr   (w_rf_waddr),
    .wr_data   (w_rf_wdata)
  );

  always_comb begin
    w_alu_y = '0;
    case (w_alu_dec.op)
      ALU_ADD: w_alu_y = r_a + r_b;
      ALU_SUB: w_alu_y = r_a - r_b;
      ALU_AND: w_alu_y = r_a & r_b;
      ALU_OR:  w_alu_y = r_a | r_b;
      ALU_SLT: w_alu_y = {{(DATA_WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      ALU_SLL: w_alu_y = r_b << w_shamt;
      default: w_alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    w_rf_we      = 1'b0;
    w_rf_waddr   = '0;
    w_rf_wdata   = '0;
    case (r_state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_pc[ADDR_WIDTH+1:2];
        if (mem_ready) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        case (w_opcode)
          c_op_lw, c_op_sw: w_next_state = ST_MEMADR;
          c_op_rtype:       w_next_state = ST_EXEC;
          c_op_addi:        w_next_state = ST_ADDIEX;
          c_op_beq:         w_next_state = ST_BRANCH;
          c_op_j:           w_next_state = ST_JUMP;
`ifdef MIPS_MC_JUMP_LINK_EN
          c_op_jal:         w_next_state = ST_JALWB;
`endif
          default:          w_next_state = ST_HALT;
        endcase
      end
      ST_MEMADR: w_next_state = (w_opcode == c_op_lw) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = r_aluout[ADDR_WIDTH+1:2];
        if (mem_ready) w_next_state = ST_MEMWB;
      end
      ST_MEMWB: begin
        w_rf_we      = 1'b1;
        w_rf_waddr   = w_rt;
        w_rf_wdata   = r_mdr;
        w_next_state = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_aluout[ADDR_WIDTH+1:2];
        mem_wdata = r_b;
        if (mem_ready) w_next_state = ST_FETCH;
      end
      ST_EXEC: begin
`ifdef MIPS_MC_JUMP_LINK_EN
        if (w_funct == c_fn_jr)  w_next_state = ST_FETCH;
        else
`endif
        if (w_alu_dec.valid)     w_next_state = ST_ALUWB;
        else                     w_next_state = ST_HALT;
      end
      ST_ALUWB: begin
        w_rf_we      = 1'b1;
        w_rf_waddr   = w_rd;
        w_rf_wdata   = r_aluout;
        w_next_state = ST_FETCH;
      end
      ST_ADDIEX: w_next_state = ST_ADDIWB;
      ST_ADDIWB: begin
        w_rf_we      = 1'b1;
        w_rf_waddr   = w_rt;
        w_rf_wdata   = r_aluout;
        w_next_state = ST_FETCH;
      end
      ST_BRANCH, ST_JUMP: w_next_state = ST_FETCH;
      ST_JALWB: begin
        // PC already holds the return address (incremented during fetch).
        w_rf_we      = 1'b1;
        w_rf_waddr   = 5'd31;
        w_rf_wdata   = r_pc;
        w_next_state = ST_FETCH;
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_HALT;
    endcase
    // The state register resets to FETCH, so the request must be masked by
    // reset itself to drop the moment reset is asserted.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      w_rf_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            r_ir <= 32'(mem_rdata);
            r_pc <= r_pc + DATA_WIDTH'(4);
          end
        end
        ST_DECODE: begin
          r_a      <= w_rd_a;
          r_b      <= w_rd_b;
          r_aluout <= r_pc + (w_simm << 2);
        end
        ST_MEMADR, ST_ADDIEX: r_aluout <= r_a + w_simm;
        ST_MEMRD: if (mem_ready) r_mdr <= mem_rdata;
        ST_EXEC: begin
          r_aluout <= w_alu_y;
`ifdef MIPS_MC_JUMP_LINK_EN
          if (w_funct == c_fn_jr) r_pc <= r_a;
`endif
        end
        ST_BRANCH: if (r_a == r_b) r_pc <= r_aluout;
        ST_JUMP, ST_JALWB: r_pc <= w_jump_tgt;
        default: ;
      endcase
    end
  end

  assign halted    = (r_state == ST_HALT);
  assign pc_dbg    = r_pc;
  assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mips_mc_core                                                 |
// | Purpose  : Directed self-checking bench for mips_mc_core (RESET_PC=0x40).  |
// |            Honours MIPS_MC_JUMP_LINK_EN for the jal/jr expectations.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mips_mc_core;

  logic        clk;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, pc_dbg;
  logic [3:0]  state_dbg;

  logic [31:0] mem [0:255];
  int          wait_lat;
  int          wait_cnt;
  int          cyc, wr_cnt, wr_cycle, req_cnt, rfw_cnt, stab_err;
  logic [7:0]  wr_addr, hold_addr;
  logic [31:0] wr_data, hold_wdata;
  logic        hold_valid, hold_we;
  int          n_assert = 0;
  int          n_fail   = 0;

  mips_mc_core #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(32'h40)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .pc_dbg    (pc_dbg),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (wait_lat == 0) ? 1'b1 : (mem_req && (wait_cnt == wait_lat));

  // Memory-side monitor: wait-state generation, write capture, stability.
  always @(posedge clk) begin
    if (reset) begin
      cyc = 0; wr_cnt = 0; wr_cycle = 0; req_cnt = 0; rfw_cnt = 0; stab_err = 0;
      wr_addr = '0; wr_data = '0; hold_valid = 1'b0;
      wait_cnt <= 0;
    end else begin
      cyc = cyc + 1;
      if (mem_req) begin
        req_cnt = req_cnt + 1;
        if (hold_valid && (mem_addr !== hold_addr || mem_we !== hold_we ||
                           mem_wdata !== hold_wdata)) stab_err = stab_err + 1;
        if (!mem_ready) begin
          hold_valid = 1'b1; hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
        end else begin
          hold_valid = 1'b0;
          if (mem_we) begin
            wr_cnt = wr_cnt + 1; wr_addr = mem_addr; wr_data = mem_wdata; wr_cycle = cyc;
          end
        end
      end else if (hold_valid) begin
        stab_err   = stab_err + 1;  // request withdrawn before completion
        hold_valid = 1'b0;
      end
      if (dut.w_rf_we && dut.w_rf_waddr != 5'd0) rfw_cnt = rfw_cnt + 1;
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic begin_test();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    wait_lat = 0;

    // --- reset state and first fetch; addi/addi/add/sw program ---
    begin_test();
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[8'h11] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[8'h12] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    mem[8'h13] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
    edges(1);
    check("rst_req",    32'(mem_req),   32'h0);
    check("rst_we",     32'(mem_we),    32'h0);
    check("rst_addr",   32'(mem_addr),  32'h0);
    check("rst_wdata",  mem_wdata,      32'h0);
    check("rst_halted", 32'(halted),    32'h0);
    check("rst_pc",     pc_dbg,         32'h40);
    check("rst_state",  32'(state_dbg), 32'h0);
    check("rst_reg1",   dut.u_regfile.r_regs[1], 32'h0);
    release_reset();
    check("first_req",  32'(mem_req),   32'h1);
    check("first_addr", 32'(mem_addr),  32'h10);
    edges(15);
    check("sw_not_yet", 32'(wr_cnt),    32'h0);
    edges(1);
    check("sw_count",   32'(wr_cnt),    32'h1);
    check("sw_addr",    32'(wr_addr),   32'h2);
    check("sw_data",    wr_data,        32'h2);
    check("sw_cycle",   32'(wr_cycle),  32'd16);
    check("prog1_pc",   pc_dbg,         32'h50);
    check("prog1_st",   32'(state_dbg), 32'h0);

    // --- ALU operations and $zero ---
    begin_test();
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[8'h11] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[8'h12] = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);   // sub $4,$1,$2
    mem[8'h13] = enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A);   // slt $5,$2,$1
    mem[8'h14] = enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h24);   // and $6,$1,$2
    mem[8'h15] = enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h25);   // or  $7,$1,$2
    mem[8'h16] = enc_r(5'd0, 5'd1, 5'd8, 5'd3, 6'h00);   // sll $8,$1,3
    mem[8'h17] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);        // addi $0,$0,7
    mem[8'h18] = enc_r(5'd0, 5'd1, 5'd9, 5'd0, 6'h20);   // add $9,$0,$1
    mem[8'h19] = enc_r(5'd1, 5'd2, 5'd10, 5'd0, 6'h2A);  // slt $10,$1,$2
    release_reset();
    edges(40);
    check("alu_sub",   dut.u_regfile.r_regs[4],  32'h8);
    check("alu_slt1",  dut.u_regfile.r_regs[5],  32'h1);
    check("alu_and",   dut.u_regfile.r_regs[6],  32'h5);
    check("alu_or",    dut.u_regfile.r_regs[7],  32'hFFFFFFFD);
    check("alu_sll",   dut.u_regfile.r_regs[8],  32'h28);
    check("zero_read", dut.u_regfile.r_regs[9],  32'h5);
    check("alu_slt0",  dut.u_regfile.r_regs[10], 32'h0);
    check("alu_pc",    pc_dbg,                   32'h68);

    // --- lw with three wait states on fetch and data read ---
    begin_test();
    wait_lat   = 3;
    mem[8'h10] = enc_i(6'h23, 5'd0, 5'd1, 16'h0080);
    mem[8'h20] = 32'hDEADBEEF;
    release_reset();
    edges(4);
    check("lw_decode",  32'(state_dbg), 32'h1);
    check("lw_dec_req", 32'(mem_req),   32'h0);
    edges(2);
    check("lw_memrd",   32'(state_dbg), 32'h3);
    check("lw_rd_req",  32'(mem_req),   32'h1);
    check("lw_rd_addr", 32'(mem_addr),  32'h20);
    edges(4);
    check("lw_memwb",   32'(state_dbg), 32'h4);
    check("lw_pre_wb",  dut.u_regfile.r_regs[1], 32'h0);
    edges(1);
    check("lw_fetch",   32'(state_dbg), 32'h0);
    check("lw_pc",      pc_dbg,         32'h44);
    check("lw_data",    dut.u_regfile.r_regs[1], 32'hDEADBEEF);
    check("lw_rf_once", 32'(rfw_cnt),   32'h1);
    check("lw_stable",  32'(stab_err),  32'h0);

    // --- reset asserted during a stalled access ---
    begin_test();
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    release_reset();
    edges(2);
    check("mid_req_on", 32'(mem_req),   32'h1);
    reset = 1'b1;
    #1;
    check("mid_req_off", 32'(mem_req),  32'h0);
    check("mid_addr",   32'(mem_addr),  32'h0);
    check("mid_pc",     pc_dbg,         32'h40);
    wait_lat = 0;

    // --- beq not taken, then beq taken back to itself ---
    begin_test();
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[8'h11] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    mem[8'h12] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
    mem[8'h13] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    release_reset();
    edges(11);
    check("beq_nt_pc",  pc_dbg,         32'h4C);
    check("beq_nt_st",  32'(state_dbg), 32'h0);
    edges(1);
    check("beq_fetch",  pc_dbg,         32'h50);
    edges(2);
    check("beq_tk_pc",  pc_dbg,         32'h4C);
    check("beq_tk_st",  32'(state_dbg), 32'h0);

    // --- illegal opcode traps to HALT ---
    begin_test();
    mem[8'h10] = 32'hFC000000;
    release_reset();
    edges(1);
    check("ill_decode", 32'(halted),    32'h0);
    edges(1);
    check("ill_halted", 32'(halted),    32'h1);
    check("ill_state",  32'(state_dbg), 32'd13);
    begin
      int base;
      base = req_cnt;
      edges(100);
      check("halt_noreq", 32'(req_cnt - base), 32'h0);
    end
    check("halt_pc",    pc_dbg,         32'h44);
    check("halt_stick", 32'(halted),    32'h1);
    reset = 1'b1;
    #1;
    check("halt_clear", 32'(halted),    32'h0);

    // --- j, then jal/jr (or halt without the jump-link option) ---
    begin_test();
    mem[8'h10] = enc_j(6'h02, 26'h40);                  // j 0x100
    mem[8'h40] = enc_j(6'h03, 26'h80);                  // jal 0x200
    mem[8'h80] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08); // jr $31
    release_reset();
    edges(3);
    check("j_pc",       pc_dbg,         32'h100);
    check("j_state",    32'(state_dbg), 32'h0);
`ifdef MIPS_MC_JUMP_LINK_EN
    edges(3);
    check("jal_pc",     pc_dbg,         32'h200);
    check("jal_ra",     dut.u_regfile.r_regs[31], 32'h104);
    edges(3);
    check("jr_pc",      pc_dbg,         32'h104);
    check("jr_state",   32'(state_dbg), 32'h0);
`else
    edges(2);
    check("jal_halt",   32'(halted),    32'h1);
    check("jal_pc",     pc_dbg,         32'h104);
    check("jal_no_ra",  dut.u_regfile.r_regs[31], 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
